// File: rtl/ppf_mac_accum.sv
// Channel-interleaved multiply-accumulate engine: TAPS products per channel are
// summed, rounded, shifted and saturated, then emitted on a valid/ready port.
module ppf_mac_accum #(
  parameter int AWIDTH    = 16,
  parameter int BWIDTH    = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 24,
  parameter int CHANNELS  = 8,
  parameter int TAPS      = 4,
  parameter int SHIFT     = 15,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AWIDTH-1:0]    s_a,
  input  logic [BWIDTH-1:0]    s_b,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [CW-1:0]        m_chan,
  output logic                 m_last,
  output logic                 m_sat
);

  localparam int PW = AWIDTH + BWIDTH;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0] CH_MAX  = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] CH_ONE  = CW'(1);
  localparam logic [TW-1:0] TAP_MAX = TW'(TAPS - 1);
  localparam logic [TW-1:0] TAP_ONE = TW'(1);
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << ((SHIFT > 0) ? (SHIFT - 1) : 0))
                : {(ACC_WIDTH+1){1'b0}};
  localparam logic signed [ACC_WIDTH:0] MAX_V =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_V =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Round-half-up, arithmetic shift, then clip; MSB of the result is the clip flag.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic [ACC_WIDTH-1:0] sum);
    logic signed [ACC_WIDTH:0] wide_v;
    logic signed [ACC_WIDTH:0] r_v;
    wide_v = {sum[ACC_WIDTH-1], sum};
    r_v    = (wide_v + RND) >>> SHIFT;
    if (r_v > MAX_V) begin
      round_sat = {1'b1, MAX_V[OUT_WIDTH-1:0]};
    end else if (r_v < MIN_V) begin
      round_sat = {1'b1, MIN_V[OUT_WIDTH-1:0]};
    end else begin
      round_sat = {1'b0, r_v[OUT_WIDTH-1:0]};
    end
  endfunction

  logic                 rdy_r;
  logic                 en_s;
  logic                 accept_s;
  logic                 load_s;
  logic [CW-1:0]        chan_r;
  logic [TW-1:0]        tap_r;
  logic                 v1_r;
  logic                 first1_r;
  logic                 last1_r;
  logic [CW-1:0]        chan1_r;
  logic [PW-1:0]        p1_r;
  logic [PW-1:0]        a_ext_s;
  logic [PW-1:0]        b_ext_s;
  logic [PW-1:0]        prod_s;
  logic [ACC_WIDTH-1:0] acc_r [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_sel_s;
  logic [ACC_WIDTH-1:0] sum_s;
  logic [OUT_WIDTH:0]   conv_s;
  logic                 m_valid_r;
  logic [OUT_WIDTH-1:0] m_data_r;
  logic [CW-1:0]        m_chan_r;
  logic                 m_last_r;
  logic                 m_sat_r;

  // The whole pipeline moves together whenever the output slot can take a result.
  assign en_s     = ~m_valid_r | m_ready;
  assign s_ready  = rdy_r & en_s & ~clear_i;
  assign accept_s = s_valid & s_ready;

  // Sign extension to the full product width keeps the low PW bits exact.
  assign a_ext_s = {{BWIDTH{s_a[AWIDTH-1]}}, s_a};
  assign b_ext_s = {{AWIDTH{s_b[BWIDTH-1]}}, s_b};
  assign prod_s  = a_ext_s * b_ext_s;

  // Stage-2 accumulate and output conversion.
  always_comb begin
    acc_sel_s = {ACC_WIDTH{1'b0}};
    if (first1_r) begin
      acc_sel_s = {ACC_WIDTH{1'b0}};
    end else begin
      acc_sel_s = acc_r[chan1_r];
    end
    sum_s  = acc_sel_s + {{(ACC_WIDTH-PW){p1_r[PW-1]}}, p1_r};
    conv_s = round_sat(sum_s);
    load_s = en_s & ~clear_i & v1_r & last1_r;
  end

  // Input-ready gate: keeps s_ready low until the first edge after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdy_r <= 1'b0;
    end else begin
      rdy_r <= 1'b1;
    end
  end

  // Tap/channel counters and stage-1 product register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      chan_r   <= {CW{1'b0}};
      tap_r    <= {TW{1'b0}};
      v1_r     <= 1'b0;
      first1_r <= 1'b0;
      last1_r  <= 1'b0;
      chan1_r  <= {CW{1'b0}};
      p1_r     <= {PW{1'b0}};
    end else if (clear_i) begin
      chan_r <= {CW{1'b0}};
      tap_r  <= {TW{1'b0}};
      v1_r   <= 1'b0;
    end else if (en_s) begin
      v1_r <= accept_s;
      if (accept_s) begin
        p1_r     <= prod_s;
        chan1_r  <= chan_r;
        first1_r <= (tap_r == {TW{1'b0}});
        last1_r  <= (tap_r == TAP_MAX);
        if (chan_r == CH_MAX) begin
          chan_r <= {CW{1'b0}};
          if (tap_r == TAP_MAX) begin
            tap_r <= {TW{1'b0}};
          end else begin
            tap_r <= tap_r + TAP_ONE;
          end
        end else begin
          chan_r <= chan_r + CH_ONE;
        end
      end
    end
  end

  // Per-channel accumulators; the first tap overwrites whatever was left behind.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= {ACC_WIDTH{1'b0}};
      end
    end else if (en_s && !clear_i && v1_r) begin
      acc_r[chan1_r] <= sum_s;
    end
  end

  // Output register: a handshake and a new load may share one edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_valid_r <= 1'b0;
      m_data_r  <= {OUT_WIDTH{1'b0}};
      m_chan_r  <= {CW{1'b0}};
      m_last_r  <= 1'b0;
      m_sat_r   <= 1'b0;
    end else if (clear_i) begin
      m_valid_r <= 1'b0;
    end else if (load_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= conv_s[OUT_WIDTH-1:0];
      m_sat_r   <= conv_s[OUT_WIDTH];
      m_chan_r  <= chan1_r;
      m_last_r  <= (chan1_r == CH_MAX);
    end else if (en_s) begin
      m_valid_r <= 1'b0;
    end
  end

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_chan  = m_chan_r;
  assign m_last  = m_last_r;
  assign m_sat   = m_sat_r;

endmodule

// File: tb/tb_ppf_mac_accum.sv
// Scoreboard bench for ppf_mac_accum: four parameter sets share one input stream,
// only the instance owning the current phase is checked.
module tb_ppf_mac_accum;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
    logic        last;
    logic [2:0]  chan;
  } res_t;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic        s_valid;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        m_ready;

  logic        rdy_a, va, la, sa;
  logic [23:0] da;
  logic [0:0]  ca;
  logic        rdy_r, vr, lr, sr;
  logic [23:0] dr;
  logic [0:0]  cr;
  logic        rdy_s, vs, ls, ss;
  logic [15:0] ds;
  logic [0:0]  cs;
  logic        rdy_d, vd, ld, sd;
  logic [23:0] dd;
  logic [2:0]  cd;

  int   checks = 0;
  int   failures = 0;
  int   phase = 0;
  res_t qa[$];
  res_t qr[$];
  res_t qs[$];
  res_t qd[$];
  int     mt = 0;
  int     mc = 0;
  longint acc_m [8];

  ppf_mac_accum #(.CHANNELS(2), .TAPS(2), .SHIFT(0)) u_a (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .s_valid(s_valid), .s_ready(rdy_a),
    .s_a(s_a), .s_b(s_b), .m_valid(va), .m_ready(m_ready), .m_data(da), .m_chan(ca),
    .m_last(la), .m_sat(sa));
  ppf_mac_accum #(.CHANNELS(1), .TAPS(1), .SHIFT(2)) u_r (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .s_valid(s_valid), .s_ready(rdy_r),
    .s_a(s_a), .s_b(s_b), .m_valid(vr), .m_ready(m_ready), .m_data(dr), .m_chan(cr),
    .m_last(lr), .m_sat(sr));
  ppf_mac_accum #(.OUT_WIDTH(16), .CHANNELS(1), .TAPS(2), .SHIFT(0)) u_s (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .s_valid(s_valid), .s_ready(rdy_s),
    .s_a(s_a), .s_b(s_b), .m_valid(vs), .m_ready(m_ready), .m_data(ds), .m_chan(cs),
    .m_last(ls), .m_sat(ss));
  ppf_mac_accum u_d (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .s_valid(s_valid), .s_ready(rdy_d),
    .s_a(s_a), .s_b(s_b), .m_valid(vd), .m_ready(m_ready), .m_data(dd), .m_chan(cd),
    .m_last(ld), .m_sat(sd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input int d, input bit s, input bit l, input int c);
    res_t r;
    r.data = d;
    r.sat  = s;
    r.last = l;
    r.chan = c[2:0];
    return r;
  endfunction

  // Reference conversion: round-half-up, arithmetic shift, clip to ow signed bits.
  function automatic longint conv(input longint s, input int sh, input int ow, output bit sat);
    longint r, hi, lo;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    if (sh > 0) r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    else r = s;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  // Scoreboard: model default instance on accepted beats, compare on every handshake.
  always @(negedge clk) begin
    longint prod, r;
    bit     sat;
    if (!rstn) begin
      qa.delete(); qr.delete(); qs.delete(); qd.delete();
      mt = 0; mc = 0;
    end else begin
      if (phase == 1 && va && m_ready) begin
        if (qa.size() == 0) chk("A_extra_out", 64'(1), 64'(0));
        else chk("A_result", 64'(mk(int'($signed(da)), sa, la, int'(ca))), 64'(qa.pop_front()));
      end
      if (phase == 2 && vr && m_ready) begin
        if (qr.size() == 0) chk("R_extra_out", 64'(1), 64'(0));
        else chk("R_result", 64'(mk(int'($signed(dr)), sr, lr, int'(cr))), 64'(qr.pop_front()));
      end
      if (phase == 3 && vs && m_ready) begin
        if (qs.size() == 0) chk("S_extra_out", 64'(1), 64'(0));
        else chk("S_result", 64'(mk(int'($signed(ds)), ss, ls, int'(cs))), 64'(qs.pop_front()));
      end
      if (phase == 4) begin
        if (vd && m_ready) begin
          if (qd.size() == 0) chk("D_extra_out", 64'(1), 64'(0));
          else chk("D_result", 64'(mk(int'($signed(dd)), sd, ld, int'(cd))), 64'(qd.pop_front()));
        end
        if (clear) begin
          mt = 0; mc = 0;
        end else if (s_valid && rdy_d) begin
          prod = longint'($signed(s_a)) * longint'($signed(s_b));
          acc_m[mc] = (mt == 0) ? prod : acc_m[mc] + prod;
          if (mt == 3) begin
            r = conv(acc_m[mc], 15, 24, sat);
            qd.push_back(mk(int'(r), sat, (mc == 7), mc));
          end
          mc++;
          if (mc == 8) begin mc = 0; mt = (mt + 1) % 4; end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the default instance accepts it.
  task automatic beat(input int a, input int b);
    int n;
    n = 0;
    s_valid = 1'b1; s_a = a[15:0]; s_b = b[15:0];
    @(negedge clk);
    while (!rdy_d && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("beat_timeout", 64'(1), 64'(0));
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; s_valid = 1'b1; s_a = 16'h1234; s_b = 16'h0777;
    @(negedge clk);
    chk("clear_s_ready", 64'(rdy_d), 64'(0));
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    chk("clear_m_valid", 64'(vd), 64'(0));
  endtask

  task automatic hold5();
    logic [63:0] held;
    held = 64'({dd, cd, ld, sd});
    chk("bp_valid_start", 64'(vd), 64'(1));
    s_valid = 1'b1; s_a = 16'h7fff; s_b = 16'h7fff;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_s_ready", 64'(rdy_d), 64'(0));
      chk("bp_m_valid", 64'(vd), 64'(1));
      chk("bp_stable", 64'({dd, cd, ld, sd}), held);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
  endtask

  task automatic run_beats(input int n, input int hold_at);
    for (int i = 0; i < n; i++) begin
      if (i == hold_at) m_ready = 1'b0;
      beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      if (i == hold_at) hold5();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 64'(rdy_d), 64'(0));
    chk({tag, "_m_valid"}, 64'(vd), 64'(0));
    chk({tag, "_m_data"}, 64'(dd), 64'(0));
    chk({tag, "_m_chan"}, 64'(cd), 64'(0));
    chk({tag, "_m_last"}, 64'(ld), 64'(0));
    chk({tag, "_m_sat"}, 64'(sd), 64'(0));
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; s_valid = 1'b0; s_a = 16'h0; s_b = 16'h0; m_ready = 1'b1;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_rel_s_ready_low", 64'(rdy_d), 64'(0));
    idle(1);
    chk("rst_rel_s_ready_high", 64'(rdy_d), 64'(1));

    // Basic two-channel, two-tap sum and latency.
    phase = 1;
    do_clear();
    qa.push_back(mk(-2, 1'b0, 1'b0, 0));
    qa.push_back(mk(31, 1'b0, 1'b1, 1));
    beat(3, 4);
    beat(5, 6);
    beat(-2, 7);
    chk("A_latency_edge1", 64'(va), 64'(0));
    beat(1, 1);
    chk("A_latency_edge2", 64'(va), 64'(1));
    idle(4);
    chk("A_drain", 64'(qa.size()), 64'(0));

    // Rounding with a single tap.
    phase = 2;
    do_clear();
    qr.push_back(mk(2, 1'b0, 1'b1, 0));
    qr.push_back(mk(-1, 1'b0, 1'b1, 0));
    qr.push_back(mk(1, 1'b0, 1'b1, 0));
    qr.push_back(mk(-1, 1'b0, 1'b1, 0));
    beat(2, 3); beat(-2, 3); beat(1, 2); beat(-3, 1);
    idle(4);
    chk("R_drain", 64'(qr.size()), 64'(0));

    // Saturation at both rails.
    phase = 3;
    do_clear();
    qs.push_back(mk(32767, 1'b1, 1'b1, 0));
    qs.push_back(mk(-32768, 1'b1, 1'b1, 0));
    beat(-32768, -32768); beat(-32768, -32768);
    beat(-32768, 32767); beat(-32768, 32767);
    idle(4);
    chk("S_drain", 64'(qs.size()), 64'(0));

    // Default parameters: free-running frame, backpressure, clear, mid-frame reset.
    phase = 4;
    do_clear();
    run_beats(32, -1);
    run_beats(32, 25);
    idle(4);
    chk("D_drain_bp", 64'(qd.size()), 64'(0));
    run_beats(11, -1);
    do_clear();
    idle(3);
    run_beats(32, -1);
    idle(4);
    chk("D_drain_clear", 64'(qd.size()), 64'(0));
    run_beats(25, -1);
    idle(1);
    chk("pre_rst_m_valid", 64'(vd), 64'(1));
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(1);
    chk("rst2_s_ready_high", 64'(rdy_d), 64'(1));
    run_beats(32, -1);
    idle(4);
    chk("D_drain_rst", 64'(qd.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
